// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. It owns the PC and drives a combinational
//            instruction memory. Fetched words go through a small in-order
//            buffer to decode over a valid/ready handshake. Execute can redirect
//            the fetch to a new PC.
// Options  : FETCH_PERF_EN adds the FetchCount and StallCount counter ports.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        FetchEn,
  output logic [63:0] IMemAddr,
  input  logic [31:0] IMemData,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC,
  output logic        IfValid,
  input  logic        IfReady,
  output logic [31:0] IfInstr,
  output logic [63:0] IfPC,
  output logic        FetchErr
`ifdef FETCH_PERF_EN
  , output logic [31:0] FetchCount
  , output logic [31:0] StallCount
`endif
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam int              CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;
  logic [63:0]        pc_buf_q    [DEPTH];
  logic [63:0]        pc_buf_d    [DEPTH];
  logic [31:0]        instr_buf_q [DEPTH];
  logic [31:0]        instr_buf_d [DEPTH];

  logic               buf_full;
  logic               do_pop;
  logic               do_push;
  logic               target_ok;

  assign buf_full  = (count_q == FULL_CNT);
  assign target_ok = (RedirectPC[1:0] == 2'b00);
  // The buffer is always empty in HALT, so the valid flag is simply the count.
  assign do_pop    = (count_q != '0) && IfReady;
  assign do_push   = (state_q == S_RUN) && FetchEn && !Redirect && (!buf_full || do_pop);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    err_d       = err_q;
    pc_buf_d    = pc_buf_q;
    instr_buf_d = instr_buf_q;

    if ((state_q != S_HALT) && Redirect) begin
      // A redirect wins over any same-cycle push or pop and empties the buffer.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (target_ok) begin
        pc_d = RedirectPC;
      end else begin
        err_d   = 1'b1;
        state_d = S_HALT;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (FetchEn) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
          if (do_push) begin
            pc_buf_d[wr_ptr_q]    = pc_q;
            instr_buf_d[wr_ptr_q] = IMemData;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            pc_d                  = pc_q + 64'd4;
          end
          count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_buf_q[i]    <= 64'h0;
        instr_buf_q[i] <= 32'h0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      pc_buf_q    <= pc_buf_d;
      instr_buf_q <= instr_buf_d;
    end
  end

  assign IMemAddr = pc_q;
  assign IfValid  = (count_q != '0);
  assign IfInstr  = instr_buf_q[rd_ptr_q];
  assign IfPC     = pc_buf_q[rd_ptr_q];
  assign FetchErr = err_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic        stall_evt;

  // A stall counts only when the full buffer itself blocks the push.
  assign stall_evt = (state_q == S_RUN) && FetchEn && !Redirect && buf_full && !do_pop;

  always_comb begin
    fetch_count_d = fetch_count_q + 32'(do_push);
    stall_count_d = stall_count_q + 32'(stall_evt);
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      fetch_count_q <= 32'h0;
      stall_count_q <= 32'h0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign FetchCount = fetch_count_q;
  assign StallCount = stall_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Testbench for fetch_unit: directed scenarios plus randomized traffic, with all
// outputs checked every cycle against a queue-based model of the fetch stage.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          M_IDLE   = 0;
  localparam int          M_RUN    = 1;
  localparam int          M_HALTED = 2;

  logic        CLK        = 1'b0;
  logic        Reset_L    = 1'b0;
  logic        FetchEn    = 1'b0;
  logic        Redirect   = 1'b0;
  logic        IfReady    = 1'b0;
  logic [63:0] RedirectPC = 64'h0;
  logic [63:0] IMemAddr;
  logic [31:0] IMemData;
  logic        IfValid;
  logic [31:0] IfInstr;
  logic [63:0] IfPC;
  logic        FetchErr;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .Reset_L    (Reset_L),
    .FetchEn    (FetchEn),
    .IMemAddr   (IMemAddr),
    .IMemData   (IMemData),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .IfValid    (IfValid),
    .IfReady    (IfReady),
    .IfInstr    (IfInstr),
    .IfPC       (IfPC),
    .FetchErr   (FetchErr)
`ifdef FETCH_PERF_EN
    , .FetchCount (FetchCount)
    , .StallCount (StallCount)
`endif
  );

  always #5 CLK = ~CLK;

  // Instruction memory contents: a fixed word at 0x20, otherwise an address-derived pattern.
  function automatic logic [31:0] imem(input logic [63:0] a);
    logic [31:0] w;
    if (a == 64'h20) return 32'h8B0901AD;
    w = 32'hF84003E9 + a[33:2] * 32'h0000_8001;
    return w ^ a[63:32];
  endfunction

  assign IMemData = imem(IMemAddr);

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of {pc, instr} plus the fetch PC and mode.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [63:0] m_pc;
  int          m_mode;
  logic        m_err;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;
  bit          m_pop;

  always @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      m_q.delete();
      m_pc    = RESET_PC;
      m_mode  = M_IDLE;
      m_err   = 1'b0;
      m_fetch = 32'h0;
      m_stall = 32'h0;
    end else begin
      m_pop = (m_mode != M_HALTED) && (m_q.size() > 0) && IfReady;
      if ((m_mode != M_HALTED) && Redirect) begin
        m_q.delete();
        if (RedirectPC[1:0] != 2'b00) begin
          m_err  = 1'b1;
          m_mode = M_HALTED;
        end else begin
          m_pc = RedirectPC;
        end
      end else if (m_mode == M_IDLE) begin
        if (FetchEn) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        if (m_pop) void'(m_q.pop_front());
        if (FetchEn) begin
          if (m_q.size() < DEPTH) begin
            m_q.push_back({m_pc, imem(m_pc)});
            m_pc    = m_pc + 64'd4;
            m_fetch = m_fetch + 32'd1;
          end else begin
            m_stall = m_stall + 32'd1;
          end
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("imem_addr", IMemAddr, m_pc);
      chk("if_valid", 64'(IfValid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("if_pc", IfPC, m_q[0].pc);
        chk("if_instr", 64'(IfInstr), 64'(m_q[0].instr));
      end
      chk("fetch_err", 64'(FetchErr), 64'(m_err));
`ifdef FETCH_PERF_EN
      chk("fetch_count", 64'(FetchCount), 64'(m_fetch));
      chk("stall_count", 64'(StallCount), 64'(m_stall));
`endif
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic fe, input logic rdy, input logic rd, input logic [63:0] rpc);
    FetchEn    = fe;
    IfReady    = rdy;
    Redirect   = rd;
    RedirectPC = rpc;
  endtask

  task automatic pulse_reset();
    Reset_L = 1'b0;
    #2;
    Reset_L = 1'b1;
  endtask

  int          kind;
  logic [63:0] tgt;

  initial begin
    Reset_L = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_addr", IMemAddr, 64'h0);
    chk("rst_valid", 64'(IfValid), 64'h0);
    chk("rst_instr", 64'(IfInstr), 64'h0);
    chk("rst_pc", IfPC, 64'h0);
    chk("rst_err", 64'(FetchErr), 64'h0);
    Reset_L = 1'b1;
    cmp_en  = 1'b1;

    // FetchEn low keeps the unit idle.
    step(); step();
    chk("idle_addr", IMemAddr, 64'h0);
    chk("idle_valid", 64'(IfValid), 64'h0);

    // Streaming with decode always ready.
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    step(); step();
    chk("s1_pc0", IfPC, 64'h0);
    chk("s1_in0", 64'(IfInstr), 64'hF84003E9);
    step();
    chk("s1_pc4", IfPC, 64'h4);
    chk("s1_in4", 64'(IfInstr), 64'hF84083EA);
    step();
    chk("s1_pc8", IfPC, 64'h8);
    chk("s1_in8", 64'(IfInstr), 64'hF84103EB);

    // Decode stalled: buffer fills, PC holds.
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    pulse_reset();
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    repeat (6) step();
    chk("s2_hold_addr", IMemAddr, 64'h8);
    chk("s2_head", IfPC, 64'h0);
`ifdef FETCH_PERF_EN
    chk("s2_stalls", 64'(StallCount), 64'd3);
`endif
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    step();
    chk("s2_pc4", IfPC, 64'h4);
    step();
    chk("s2_pc8", IfPC, 64'h8);

    // Redirect flushes buffered words.
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    pulse_reset();
    drive(1'b0, 1'b0, 1'b1, 64'h10);
    step();
    chk("s3_idle_redir", IMemAddr, 64'h10);
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    step(); step(); step();
    chk("s3_head10", IfPC, 64'h10);
    chk("s3_addr18", IMemAddr, 64'h18);
    drive(1'b1, 1'b0, 1'b1, 64'h20);
    step();
    chk("s3_flush_valid", 64'(IfValid), 64'h0);
    chk("s3_addr20", IMemAddr, 64'h20);
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    step();
    chk("s3_valid20", 64'(IfValid), 64'h1);
    chk("s3_pc20", IfPC, 64'h20);
    chk("s3_in20", 64'(IfInstr), 64'h8B0901AD);

    // Misaligned redirect halts the unit until reset.
    drive(1'b0, 1'b1, 1'b1, 64'h22);
    step();
    chk("s4_err", 64'(FetchErr), 64'h1);
    chk("s4_valid", 64'(IfValid), 64'h0);
    chk("s4_addr", IMemAddr, 64'h24);
    drive(1'b1, 1'b1, 1'b1, 64'h0);
    step(); step();
    chk("s4_frozen_addr", IMemAddr, 64'h24);
    chk("s4_frozen_valid", 64'(IfValid), 64'h0);

    // PC wraps at 2^64.
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    pulse_reset();
    chk("s5_err_clr", 64'(FetchErr), 64'h0);
    drive(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    step();
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    step(); step(); step();
    chk("s5_wrap_addr", IMemAddr, 64'h0);
    chk("s5_wrap_head", IfPC, 64'hFFFF_FFFF_FFFF_FFFC);

    // Asynchronous reset between edges.
    step(); step();
    chk("s6_pre_valid", 64'(IfValid), 64'h1);
    Reset_L = 1'b0;
    #1;
    chk("s6_async_valid", 64'(IfValid), 64'h0);
    chk("s6_async_addr", IMemAddr, RESET_PC);
    #1;
    Reset_L = 1'b1;

    // Randomized traffic.
    repeat (4000) begin
      kind = int'($urandom_range(0, 7));
      case (kind)
        0:       tgt = {$urandom, $urandom} | 64'h1;
        1, 2:    tgt = 64'hFFFF_FFFF_FFFF_FFF0 + {60'h0, 2'($urandom_range(0, 3)), 2'b00};
        3:       tgt = {$urandom, $urandom} & ~64'h3;
        default: tgt = {56'h0, 6'($urandom_range(0, 63)), 2'b00};
      endcase
      drive(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 99) < 6), tgt);
      if ($urandom_range(0, 199) == 0 || (m_mode == M_HALTED && $urandom_range(0, 19) == 0)) begin
        pulse_reset();
      end
      step();
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
